rr_dec_arbiter: RTL
===================

# rr_dec_arbiter

Round-robin arbiter that shares one 3-to-8 decoded select resource among eight requesters. It produces the 3-bit decoder address and enable, plus an active-low one-hot grant bus. It bounds each owner's tenure with a hold timeout and inserts a programmable dead gap between owners. It sits in front of the lab's decoder datapath and is the single source of its address and enable.

## Interface

**Parameters**

- `MAX_HOLD`, default 16: maximum grant tenure in cycles; legal range 1..255.
- `GAP`, default 1: dead cycles between grants, with enable low; legal range 1..15.

**Ports**

- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: request lines; `req[i]` high means requester i wants the resource.
- `done` input 1: the current owner releases; sampled only in GRANT.
- `sel` output 3: decoder address, equal to the index of the current owner.
- `en` output 1: decoder enable; high only in GRANT.
- `gnt_n` output 8: active-low one-hot grant.
  - Bit `sel` is low when `en` is 1.
  - All ones otherwise.
  - Standard mapping: bit i belongs to requester i, with no scrambling.
- `busy` output 1: high in GRANT and GAP.
- `timeout` output 1: one-cycle pulse when a grant is force-released.

## Operation

**States**

- IDLE, GRANT, GAP.
- `state`, `sel`, `en`, `gnt_n`, `busy`, `timeout`, `ptr` and the counters are all registered.

**Reset values**

- state=IDLE, sel=0, en=0, gnt_n=8'hFF, busy=0, timeout=0.
- ptr=0, hold_cnt=0, gap_cnt=0.

**Arbitration function (combinational)**

- Pick the first i with req[i]=1, scanning ptr, ptr+1, …, ptr+7 mod 8.
- With no request, nothing is selected.

**IDLE**

- If any req: go to GRANT with sel=winner, en=1, gnt_n=~(1<<winner), busy=1, hold_cnt=0.
- Otherwise stay in IDLE with outputs at their reset values.

**GRANT**

- Release conditions, evaluated each cycle:
  - (a) done=1.
  - (b) req[sel]=0 (requester withdrew).
  - (c) hold_cnt==MAX_HOLD-1.
- Any release:
  - Go to GAP with en=0, gnt_n=8'hFF, gap_cnt=0.
  - Set ptr=sel+1 mod 8.
  - sel keeps its value.
- timeout=1 for the next cycle only if (c) holds and neither (a) nor (b) holds. A voluntary release wins over a simultaneous timeout.
- With no release, hold_cnt increments.

**GAP**

- en=0, busy=1; gap_cnt increments each cycle.
- When gap_cnt==GAP-1, arbitrate using the updated ptr:
  - Winner present: go directly to GRANT, with the same register updates as from IDLE.
  - No winner: go to IDLE with busy=0.

**Fairness**

- The last owner has the lowest priority in the next arbitration.
- The scan wraps from 7 to 0.

**Requests in other states**

- Requests in GAP are ignored until its final cycle.
- Changes of req bits other than req[sel] during GRANT have no effect.

**Reset mid-operation**

- Reset forces all reset values immediately, with no wait for a clock edge.
- After reset, ptr=0, so requester 0 has top priority.

## Timing

- The arbiter does not assert `en` in the same cycle a request arrives.
- Request latency: req sampled in IDLE at edge t gives en=1, sel and gnt_n valid after edge t+1, with one registered stage.
- Release latency: done=1 at edge t gives en=0 and gnt_n=8'hFF after edge t+1.
- Handoff: the next owner's en rises after edge t+1+GAP. With GAP=1, en is low for exactly one cycle.
- Timeout tenure: en is high for exactly MAX_HOLD cycles, and timeout pulses during the first GAP cycle.
- Output invariants:
  - sel and gnt_n never change while en=1.
  - gnt_n is never 2-hot.
  - en=1 implies gnt_n has exactly one zero, at bit sel.

## Test plan

- **Reset:** assert rst asynchronously mid-cycle during a GRANT.
  - Required: immediately en=0, gnt_n=8'hFF, sel=0, busy=0, timeout=0.
  - After release, req=8'h01 gives a grant to 0.
- **Single request:** req=8'h20 from IDLE.
  - Required: the next cycle has sel=5, en=1, gnt_n=8'hDF.
  - done pulse: en=0 one cycle later, then one GAP cycle, then a regrant to 5 while req is still held.
- **Full round-robin:** req=8'hFF held, with done asserted on the first GRANT cycle of each tenure.
  - Required: grant order 0,1,2,3,4,5,6,7,0, with en low exactly GAP cycles between grants.
- **Wrap priority:** after owner 6 releases, req=8'h82.
  - Required: grant 7 first, then 1.
- **Timeout (MAX_HOLD=4):** req=8'h04 held, done never asserted.
  - Required: en high exactly 4 cycles, timeout pulses 1 cycle, then a regrant to 2 after GAP.
  - done asserted on the 4th cycle: no timeout pulse.
- **Withdrawal:** owner 3 drops req[3] in GRANT.
  - Required: release on the next edge with no timeout pulse, and ptr=4, so a pending req[3]|req[4] is granted to 4.

Source files
------------

// File: rtl/rr_dec_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoded select, with a hold
// timeout per tenure and a programmable dead gap between owners.
module rr_dec_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int GAP      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt_n,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_sel;
    logic       r_en;
    logic [7:0] r_gnt_n;
    logic       r_busy;
    logic       r_timeout;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gap_cnt;

    logic       w_any;
    logic [2:0] w_win;
    logic [2:0] w_idx;
    logic       w_rel_vol;
    logic       w_rel_to;
    logic       w_gap_end;

    // Scan from highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = 3'd0;
        w_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_idx = r_ptr + 3'(k);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_rel_vol = done || !req[r_sel];
    assign w_rel_to  = (r_hold_cnt == 8'(MAX_HOLD - 1));
    assign w_gap_end = (r_gap_cnt == 4'(GAP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 3'd0;
            r_en       <= 1'b0;
            r_gnt_n    <= 8'hFF;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= 3'd0;
            r_hold_cnt <= 8'd0;
            r_gap_cnt  <= 4'd0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_GRANT;
                        r_sel      <= w_win;
                        r_en       <= 1'b1;
                        r_gnt_n    <= ~(8'd1 << w_win);
                        r_busy     <= 1'b1;
                        r_hold_cnt <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (w_rel_vol || w_rel_to) begin
                        r_state   <= S_GAP;
                        r_en      <= 1'b0;
                        r_gnt_n   <= 8'hFF;
                        r_gap_cnt <= 4'd0;
                        r_ptr     <= r_sel + 3'd1;
                        r_timeout <= w_rel_to && !w_rel_vol;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        if (w_any) begin
                            r_state    <= S_GRANT;
                            r_sel      <= w_win;
                            r_en       <= 1'b1;
                            r_gnt_n    <= ~(8'd1 << w_win);
                            r_hold_cnt <= 8'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_sel   <= 3'd0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_gnt_n <= 8'hFF;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel     = r_sel;
    assign en      = r_en;
    assign gnt_n   = r_gnt_n;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
